// File: rtl/rvfi_pkg.sv
// RVFI record types shared by the commit serializer, its storage and the bench.
package rvfi_pkg;

    localparam int unsigned XLEN = 32;

    // One retired (or trapping) instruction as reported on an RVFI commit port.
    typedef struct packed {
        logic            valid;
        logic [31:0]     insn;
        logic            trap;
        logic [XLEN-1:0] cause;
        logic            halt;
        logic            intr;
        logic [1:0]      mode;
        logic [4:0]      rs1_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
    } rvfi_instr_t;

    // Buffered record together with its commit-order stamp.
    typedef struct packed {
        rvfi_instr_t instr;
        logic [63:0] order;
    } rvfi_stamped_t;

endpackage

// File: rtl/rvfi_mpush_fifo.sv
// Multi-push / single-pop FIFO with first-word fall-through head.
// Up to NPUSH contiguous entries are written per cycle starting at the write pointer.
module rvfi_mpush_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NPUSH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  T                           push_data_i [NPUSH],
    input  logic [$clog2(NPUSH+1)-1:0] push_cnt_i,
    input  logic                       pop_i,
    output T                           head_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(NPUSH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [LW-1:0] level_q;

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NPUSH; k++) begin
                if (CW'(k) < push_cnt_i) begin
                    mem_q[wptr_q + PW'(k)] <= push_data_i[k];
                end
            end
            wptr_q  <= wptr_q + PW'(push_cnt_i);
            rptr_q  <= rptr_q + PW'(pop_i);
            level_q <= level_q + LW'(push_cnt_i) - LW'(pop_i);
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serialises a multi-port RVFI commit bundle into an order-stamped single-record stream.
// Records that do not fit in the buffer are dropped and counted; there is no backpressure.
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output rvfi_pkg::rvfi_instr_t                     rvfi_o,
    output logic [63:0]                               order_o,
    output logic                                      rvfi_valid_o,
    input  logic                                      rvfi_ready_i,
    output logic [$clog2(DEPTH):0]                    level_o,
    output logic [31:0]                               drop_cnt_o,
    output logic                                      overflow_o
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

    logic [NR_COMMIT_PORTS-1:0] qual;
    logic [CW-1:0]              rank [NR_COMMIT_PORTS];
    logic [CW-1:0]              run_cnt;
    logic [CW-1:0]              q_cnt;
    logic [CW-1:0]              acc_cnt;
    logic [CW-1:0]              drop_now;
    logic [LW-1:0]              free;
    logic [LW-1:0]              level;
    logic [32:0]                drop_sum;
    rvfi_stamped_t              push_data [NR_COMMIT_PORTS];
    rvfi_stamped_t              head;
    logic                       pop;

    logic [63:0] ord_q, ord_d;
    logic [31:0] drop_q, drop_d;
    logic        ovf_q, ovf_d;

    // Qualify each port and compute its rank among this cycle's qualifying records.
    always_comb begin
        run_cnt = '0;
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            qual[i] = rvfi_i[i].valid || rvfi_i[i].trap;
            rank[i] = run_cnt;
            run_cnt = run_cnt + CW'(qual[i]);
        end
        q_cnt = run_cnt;
    end

    // Pack qualifying records contiguously in port order and stamp each with ord + rank.
    always_comb begin
        for (int unsigned j = 0; j < NR_COMMIT_PORTS; j++) begin
            push_data[j] = '0;
            for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (qual[i] && (rank[i] == CW'(j))) begin
                    push_data[j].instr = rvfi_i[i];
                    push_data[j].order = ord_q + 64'(rank[i]);
                end
            end
        end
    end

    // Acceptance against start-of-cycle free space, drop accounting and order advance.
    always_comb begin
        free     = LW'(DEPTH) - level;
        acc_cnt  = (LW'(q_cnt) > free) ? free[CW-1:0] : q_cnt;
        drop_now = q_cnt - acc_cnt;
        drop_sum = {1'b0, drop_q} + 33'(drop_now);
        drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
        ovf_d    = ovf_q | (drop_now != '0);
        ord_d    = ord_q + 64'(q_cnt);
    end

    // Order counter and loss reporting registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ord_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ord_q  <= ord_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pop = rvfi_valid_o && rvfi_ready_i;

    rvfi_mpush_fifo #(
        .T     (rvfi_stamped_t),
        .DEPTH (DEPTH),
        .NPUSH (NR_COMMIT_PORTS)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_data_i (push_data),
        .push_cnt_i  (acc_cnt),
        .pop_i       (pop),
        .head_o      (head),
        .level_o     (level)
    );

    assign rvfi_valid_o = (level != '0);
    assign rvfi_o       = head.instr;
    assign order_o      = head.order;
    assign level_o      = level;
    assign drop_cnt_o   = drop_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Randomised and directed bench for rvfi_commit_serializer with a queue-based reference model.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 16;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b1;
    rvfi_instr_t [NR-1:0]    rin;
    rvfi_instr_t             rout;
    logic [63:0]             order;
    logic                    vld;
    logic                    rdy;
    logic [$clog2(DEPTH):0]  level;
    logic [31:0]             drop;
    logic                    ovf;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: expected buffer contents plus occupancy, order and loss counters.
    rvfi_stamped_t   exp_q[$];
    int unsigned     mlevel = 0;
    longint unsigned mord   = 0;
    longint unsigned mdrop  = 0;
    bit              movf   = 1'b0;

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS (NR),
        .DEPTH           (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rvfi_i       (rin),
        .rvfi_o       (rout),
        .order_o      (order),
        .rvfi_valid_o (vld),
        .rvfi_ready_i (rdy),
        .level_o      (level),
        .drop_cnt_o   (drop),
        .overflow_o   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model update at each active edge from the inputs presented for that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) begin
                int unsigned free;
                int unsigned acc;
                bit          pop_m;
                pop_m = (mlevel != 0) && rdy;
                free  = DEPTH - mlevel;
                acc   = 0;
                for (int i = 0; i < NR; i++) begin
                    if (rin[i].valid || rin[i].trap) begin
                        if (acc < free) begin
                            exp_q.push_back('{instr: rin[i], order: mord});
                            acc++;
                        end else begin
                            if (mdrop < 64'hFFFF_FFFF) mdrop++;
                            movf = 1'b1;
                        end
                        mord++;
                    end
                end
                mlevel = mlevel + acc - (pop_m ? 1 : 0);
            end
        end
    end

    // Monitor: compares status every cycle and the head record whenever it is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("valid", 256'(vld), 256'(mlevel != 0));
                chk("level", 256'(level), 256'(mlevel));
                chk("drop_cnt", 256'(drop), 256'(mdrop));
                chk("overflow", 256'(ovf), 256'(movf));
                if (vld) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL head_unexpected actual=valid order=%0h expected=empty", order);
                    end else begin
                        chk("head_instr", 256'(rout), 256'(exp_q[0].instr));
                        chk("head_order", 256'(order), 256'(exp_q[0].order));
                        if (rdy) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    function automatic rvfi_instr_t mk(input bit v, input bit t, input logic [31:0] pc);
        rvfi_instr_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = t;
        r.pc_rdata = pc;
        r.pc_wdata = pc + 32'd4;
        r.insn     = $urandom();
        return r;
    endfunction

    function automatic rvfi_instr_t rnd_rec(input int unsigned pv);
        rvfi_instr_t r;
        r.valid     = ($urandom_range(99) < pv);
        r.insn      = $urandom();
        r.trap      = ($urandom_range(99) < 8);
        r.cause     = $urandom();
        r.halt      = 1'($urandom());
        r.intr      = 1'($urandom());
        r.mode      = 2'($urandom());
        r.rs1_addr  = 5'($urandom());
        r.rd_addr   = 5'($urandom());
        r.rd_wdata  = $urandom();
        r.pc_rdata  = $urandom();
        r.pc_wdata  = $urandom();
        r.mem_addr  = $urandom();
        r.mem_rmask = 4'($urandom());
        r.mem_wmask = 4'($urandom());
        return r;
    endfunction

    // Present one cycle of stimulus; returns 2 time units after the edge that consumed it.
    task automatic step(input rvfi_instr_t a, input rvfi_instr_t b, input logic r);
        rin[0] = a;
        rin[1] = b;
        rdy    = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rin   = '0;
        rdy   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 256'(vld), 256'(0));
        chk("rst_rvfi", 256'(rout), 256'(0));
        chk("rst_order", 256'(order), 256'(0));
        chk("rst_level", 256'(level), 256'(0));
        chk("rst_drop", 256'(drop), 256'(0));
        chk("rst_overflow", 256'(ovf), 256'(0));
        exp_q.delete();
        mlevel = 0;
        mord   = 0;
        mdrop  = 0;
        movf   = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rin = '0;
        rdy = 1'b0;

        // Single-port accept
        do_reset();
        step(mk(1'b1, 1'b0, 32'h8000_0000), '0, 1'b1);
        chk("t1_valid", 256'(vld), 256'(1));
        chk("t1_pc", 256'(rout.pc_rdata), 256'(32'h8000_0000));
        chk("t1_order", 256'(order), 256'(0));
        chk("t1_level", 256'(level), 256'(1));
        step('0, '0, 1'b1);
        chk("t1_level_after", 256'(level), 256'(0));

        // Dual commit ordering
        do_reset();
        step(mk(1'b1, 1'b0, 32'h100), mk(1'b1, 1'b0, 32'h104), 1'b1);
        chk("t2_pc0", 256'(rout.pc_rdata), 256'(32'h100));
        chk("t2_ord0", 256'(order), 256'(0));
        step('0, '0, 1'b1);
        chk("t2_pc1", 256'(rout.pc_rdata), 256'(32'h104));
        chk("t2_ord1", 256'(order), 256'(1));
        step('0, '0, 1'b1);

        // Trap record and a skipped hole
        do_reset();
        begin
            rvfi_instr_t tr;
            tr       = mk(1'b0, 1'b1, 32'h200);
            tr.cause = 32'd2;
            step(tr, mk(1'b1, 1'b0, 32'h204), 1'b1);
        end
        chk("t3_trap", 256'(rout.trap), 256'(1));
        chk("t3_cause", 256'(rout.cause), 256'(2));
        chk("t3_ord0", 256'(order), 256'(0));
        step('0, '0, 1'b1);
        chk("t3_pc1", 256'(rout.pc_rdata), 256'(32'h204));
        chk("t3_ord1", 256'(order), 256'(1));
        step(mk(1'b0, 1'b0, 32'h2FC), mk(1'b1, 1'b0, 32'h300), 1'b1);
        chk("t3_hole_pc", 256'(rout.pc_rdata), 256'(32'h300));
        chk("t3_hole_ord", 256'(order), 256'(2));
        chk("t3_hole_level", 256'(level), 256'(1));
        step('0, '0, 1'b1);

        // Overflow with gap in order stamps
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(mk(1'b1, 1'b0, 32'h1000 + 32'(8 * i)), mk(1'b1, 1'b0, 32'h1004 + 32'(8 * i)), 1'b0);
        end
        chk("t4_level", 256'(level), 256'(16));
        chk("t4_drop", 256'(drop), 256'(2));
        chk("t4_overflow", 256'(ovf), 256'(1));
        chk("t4_head_ord", 256'(order), 256'(0));
        for (int i = 0; i < 16; i++) step('0, '0, 1'b1);
        chk("t4_drained", 256'(level), 256'(0));
        step(mk(1'b1, 1'b0, 32'h2000), '0, 1'b1);
        chk("t4_next_ord", 256'(order), 256'(18));
        chk("t4_sticky", 256'(ovf), 256'(1));
        step('0, '0, 1'b1);

        // Full buffer with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(mk(1'b1, 1'b0, 32'h3000 + 32'(8 * i)), mk(1'b1, 1'b0, 32'h3004 + 32'(8 * i)), 1'b0);
        end
        chk("t5_full", 256'(level), 256'(16));
        chk("t5_nodrop", 256'(drop), 256'(0));
        step(mk(1'b1, 1'b0, 32'h4000), '0, 1'b1);
        chk("t5_drop", 256'(drop), 256'(1));
        chk("t5_level", 256'(level), 256'(15));
        chk("t5_overflow", 256'(ovf), 256'(1));
        for (int i = 0; i < 16; i++) step('0, '0, 1'b1);

        // Reset mid-stream
        do_reset();
        step(mk(1'b1, 1'b0, 32'h10), mk(1'b1, 1'b0, 32'h14), 1'b0);
        step(mk(1'b1, 1'b0, 32'h18), mk(1'b1, 1'b0, 32'h1C), 1'b0);
        step(mk(1'b0, 1'b1, 32'h20), '0, 1'b0);
        chk("t6_level5", 256'(level), 256'(5));
        do_reset();
        step(mk(1'b1, 1'b0, 32'h500), '0, 1'b1);
        chk("t6_ord", 256'(order), 256'(0));
        chk("t6_overflow", 256'(ovf), 256'(0));
        chk("t6_valid", 256'(vld), 256'(1));
        step('0, '0, 1'b1);

        // Randomised traffic across load phases, with one reset in the middle
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            int unsigned pv;
            int unsigned pr;
            pv = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 90);
            pr = (ph % 2 == 0) ? 80 : 35;
            if (ph == 3) do_reset();
            for (int c = 0; c < 400; c++) begin
                step(rnd_rec(pv), rnd_rec(pv), ($urandom_range(99) < pr));
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) step('0, '0, 1'b1);
        chk("final_empty", 256'(level), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_serializer.md
# rvfi_commit_serializer

Testbench stage directly upstream of the RVFI tracer. It takes the core's multi-port RVFI commit bundle, keeps every record that is valid or trapping, and buffers it in commit order. It presents the records one per cycle on a valid/ready stream for a single-port consumer, and stamps each record with a monotonically increasing order number. Buffer overruns are counted, never hidden.

## Interface
- `NR_COMMIT_PORTS`, default 2: number of RVFI commit ports; range 1–4.
- `DEPTH`, default 16: buffer entries; power of two, ≥ 2·NR_COMMIT_PORTS.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `rvfi_i`  in  `rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]`: commit bundle; port 0 is the oldest.
- `rvfi_o`  out  `rvfi_pkg::rvfi_instr_t`: head record.
- `order_o`  out  64: order stamp of the head record.
- `rvfi_valid_o`  out  1: head record is valid.
- `rvfi_ready_i`  in  1: consumer accepts the head record.
- `level_o`  out  $clog2(DEPTH)+1: current occupancy.
- `drop_cnt_o`  out  32: records dropped; saturates at 32'hFFFF_FFFF.
- `overflow_o`  out  1: sticky, set on the first drop.

## Operation
- **Qualifying record:** `rvfi_i[i].valid || rvfi_i[i].trap`. All other port slots are ignored.
- **Push order:** qualifying records are pushed in ascending port index, packed contiguously with no holes.
- **Free space:** `DEPTH - level` as sampled at the start of the cycle. A same-cycle pop does not add space.
- **Acceptance:** if the number of qualifying records q exceeds free space s, the lowest-index s records are accepted. The remaining q−s are dropped.
- **Drop accounting:** `drop_cnt_o` increases by q−s, saturating. `overflow_o` sets and holds until reset.
- **Order stamp:** a 64-bit counter `ord`, reset to 0. Each qualifying record, whether accepted or dropped, takes stamp `ord + k`, where k is its rank among that cycle's qualifying records. `ord` then advances by q. Dropped records therefore leave visible gaps in `order_o`.
- **Pop:** occurs when `rvfi_valid_o && rvfi_ready_i`. The read pointer advances by 1.
- **Output:** `rvfi_valid_o = (level != 0)`. `rvfi_o` and `order_o` show the head entry as first-word fall-through from storage.
  - While valid and not ready, `rvfi_o` and `order_o` hold stable.
- **Occupancy:** `level_next = level + accepted − pop`. Simultaneous push and pop is legal in every state, including full and empty.
- **Pointer width:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Flow control:** there is no backpressure toward the core. Loss is reported only through `drop_cnt_o` and `overflow_o`.

## Timing
- **Reset values:** on assertion of `rst_ni`, every output goes to 0 immediately (asynchronously): `rvfi_valid_o`, `rvfi_o` ('0), `order_o`, `level_o`, `drop_cnt_o`, `overflow_o`. Pointers and `ord` also clear.
- **Reset mid-operation:** buffered contents are discarded with no drain. The first record after reset is stamped 0.
- **Latency:** a record sampled at edge N appears on `rvfi_o` / `rvfi_valid_o` after edge N if the buffer was empty. Otherwise it appears after the older records have drained.
- **Throughput:** one record per cycle out and up to NR_COMMIT_PORTS in.
- **Counter updates:** `level_o`, `drop_cnt_o` and `overflow_o` update at the same edge as the push/pop that changes them.
- **Empty, no ready:** when empty, `rvfi_ready_i` has no effect and `rvfi_o` is don't-care (driven from the stale head).

## Structure
- In `rvfi_pkg`: add typedef `rvfi_stamped_t` = {`rvfi_instr_t instr`; `logic [63:0] order`}. This is the storage element type.
- Sub-module `rvfi_mpush_fifo`, parameterised on entry type, DEPTH and push width. It provides multi-push / single-pop storage, pointers and level.
- The top level holds the qualification logic, the packing/prefix-count logic, the order counter and the drop accounting.

## Test plan
1. **Single-port accept:** port 0 valid with `pc_rdata`=0x8000_0000 and `rvfi_ready_i`=1 → next cycle `rvfi_valid_o`=1, `rvfi_o.pc_rdata`=0x8000_0000, `order_o`=0, `level_o`=1. The cycle after, `level_o`=0.
2. **Dual commit ordering:** ports 0 and 1 valid with pc 0x100 and 0x104, ready=1 → outputs 0x100 (order 0) then 0x104 (order 1) on consecutive cycles.
3. **Trap and hole:** port 0 invalid with trap=1 and cause 2, port 1 valid → trap record at order 0, port-1 record at order 1. A slot with neither valid nor trap is skipped.
4. **Overflow:** DEPTH=16, ready=0, 9 cycles of dual commits (18 records) → `level_o`=16, `drop_cnt_o`=2, `overflow_o`=1. Draining returns orders 0..15; the next accepted record has order 18.
5. **Full with simultaneous push and pop:** full buffer, ready=1, one qualifying record → record dropped (space was 0), `drop_cnt_o`+1, `level_o`=15.
6. **Reset mid-stream:** assert `rst_ni`=0 with level 5 → all outputs 0 asynchronously. After release, the first record has order 0 and `overflow_o`=0.
